servo_slew_ctrl: RTL and testbench



---
 rtl/servo_slew_ctrl.sv | 134 +++++++++++++
 tb/tb_servo_slew_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/servo_slew_ctrl.sv
// Servo command stage: clamps target pulse widths and slews the live width by at most STEP per PWM frame.
// Optional self-sweep mode (PW_MAX/PW_MIN alternation) is built when SERVO_SLEW_SWEEP_EN is defined.
module servo_slew_ctrl #(
  parameter int CNT_W       = 20,
  parameter int PW_MIN      = 11200,
  parameter int PW_NEUTRAL  = 40350,
  parameter int PW_MAX      = 69500,
  parameter int STEP        = 290,
  parameter int HOLD_FRAMES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick_i,
  input  logic             cmd_valid_i,
  input  logic [CNT_W-1:0] cmd_pos_i,
`ifdef SERVO_SLEW_SWEEP_EN
  input  logic             sweep_en_i,
`endif
  output logic             cmd_ready_o,
  output logic [CNT_W-1:0] pulse_width_o,
  output logic             busy_o,
  output logic             at_target_o
);

  localparam int HC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CNT_W-1:0] P_MIN  = CNT_W'(PW_MIN);
  localparam logic [CNT_W-1:0] P_NEU  = CNT_W'(PW_NEUTRAL);
  localparam logic [CNT_W-1:0] P_MAX  = CNT_W'(PW_MAX);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_HOLD} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pw_q, pw_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0] diff;
  logic             up;
  logic             issue;
  logic [CNT_W-1:0] issue_pos;

  function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v);
    if (v < P_MIN) return P_MIN;
    if (v > P_MAX) return P_MAX;
    return v;
  endfunction

  // Larger-minus-smaller keeps the distance unsigned without wrap.
  assign up   = (tgt_q > pw_q);
  assign diff = up ? (tgt_q - pw_q) : (pw_q - tgt_q);

`ifdef SERVO_SLEW_SWEEP_EN
  logic sweep_lo_q, sweep_lo_d;
  logic self_issue;

  assign self_issue = sweep_en_i && !cmd_valid_i;

  always_comb begin
    issue      = cmd_valid_i || self_issue;
    issue_pos  = cmd_valid_i ? cmd_pos_i : (sweep_lo_q ? P_MIN : P_MAX);
    sweep_lo_d = sweep_lo_q;
    if (state_q == S_IDLE && self_issue) sweep_lo_d = !sweep_lo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sweep_lo_q <= 1'b0;
    else        sweep_lo_q <= sweep_lo_d;
  end
`else
  always_comb begin
    issue     = cmd_valid_i;
    issue_pos = cmd_pos_i;
  end
`endif

  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        // A frame_tick coinciding with the accept is deliberately not used for stepping.
        if (issue) begin
          tgt_d = clamp(issue_pos);
          if (tgt_d != pw_q) state_d = S_RAMP;
        end
      end
      S_RAMP: begin
        if (frame_tick_i) begin
          if (diff <= STEP_C) begin
            pw_d    = tgt_q;
            hold_d  = '0;
            state_d = (HOLD_FRAMES == 0) ? S_IDLE : S_HOLD;
          end else begin
            pw_d = up ? (pw_q + STEP_C) : (pw_q - STEP_C);
          end
        end
      end
      S_HOLD: begin
        if (frame_tick_i) begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            state_d = S_IDLE;
          end else begin
            hold_d = hold_q + HC_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pw_q    <= P_NEU;
      tgt_q   <= P_NEU;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pw_q    <= pw_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
    end
  end

  assign cmd_ready_o   = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign pulse_width_o = pw_q;
  assign at_target_o   = (pw_q == tgt_q);

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Bench for servo_slew_ctrl: abstract position/target/hold model checked every cycle, plus literal pins.
module tb_servo_slew_ctrl;
  localparam int CNT_W = 20;
  localparam int MINV = 11200, NEU = 40350, MAXV = 69500, STEP = 290, HOLD = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_tick = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [CNT_W-1:0] cmd_pos = '0;
  logic             cmd_ready, busy, at_target;
  logic [CNT_W-1:0] pulse_width;
`ifdef SERVO_SLEW_SWEEP_EN
  logic             sweep_en = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  servo_slew_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick_i (frame_tick),
    .cmd_valid_i  (cmd_valid),
    .cmd_pos_i    (cmd_pos),
`ifdef SERVO_SLEW_SWEEP_EN
    .sweep_en_i   (sweep_en),
`endif
    .cmd_ready_o  (cmd_ready),
    .pulse_width_o(pulse_width),
    .busy_o       (busy),
    .at_target_o  (at_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: live width, target, and frames of settling still owed. Busy means
  // either not yet at target or settling frames remain.
  int m_pw = NEU, m_tgt = NEU, m_hold = 0;
  logic m_busy;
  assign m_busy = (m_pw != m_tgt) || (m_hold != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pw   <= NEU;
      m_tgt  <= NEU;
      m_hold <= 0;
    end else begin : mdl
      int pw, tgt, hold, d, cp;
      pw = m_pw; tgt = m_tgt; hold = m_hold;
      if (!m_busy) begin
        if (cmd_valid) begin
          cp  = int'(cmd_pos);
          tgt = (cp < MINV) ? MINV : (cp > MAXV) ? MAXV : cp;
        end
      end else if (frame_tick) begin
        if (pw != tgt) begin
          d = tgt - pw;
          if (d > STEP)       pw = pw + STEP;
          else if (d < -STEP) pw = pw - STEP;
          else begin
            pw   = tgt;
            hold = HOLD;
          end
        end else begin
          hold = hold - 1;
        end
      end
      m_pw   <= pw;
      m_tgt  <= tgt;
      m_hold <= hold;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("pulse_width", int'(pulse_width), m_pw);
      chk("cmd_ready", int'(cmd_ready), int'(!m_busy));
      chk("busy", int'(busy), int'(m_busy));
      chk("at_target", int'(at_target), int'(m_pw == m_tgt));
      chk("range", int'(pulse_width >= MINV && pulse_width <= MAXV), 1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int gap);
    frame_tick = 1'b0;
    repeat (gap) cyc();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic send(input int pos);
    frame_tick = 1'b0;
    cmd_valid  = 1'b1;
    cmd_pos    = CNT_W'(pos);
    cyc();
    cmd_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    frame_tick = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic run_idle();
    for (int i = 0; i < 500 && m_busy; i++) tick(1 + (i % 3));
    chk("idle_reached", int'(cmd_ready), 1);
  endtask

  initial begin
    cyc();
    do_reset();
    chk("rst_pw", int'(pulse_width), NEU);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_at_target", int'(at_target), 1);
    chk("rst_busy", int'(busy), 0);
    repeat (5) tick(6);
    chk("quiet_pw", int'(pulse_width), NEU);

    // Full-right ramp with rejected commands during ramp and hold
    send(69500);
    chk("accept_busy", int'(busy), 1);
    tick(3);
    chk("step1", int'(pulse_width), 40640);
    tick(2);
    chk("step2", int'(pulse_width), 40930);
    cmd_valid = 1'b1;
    cmd_pos   = CNT_W'(11200);
    repeat (98) tick(1);
    cmd_valid = 1'b0;
    tick(2);
    chk("ramp_end", int'(pulse_width), 69500);
    chk("hold_ready", int'(cmd_ready), 0);
    cmd_valid = 1'b1;
    repeat (9) tick(2);
    chk("hold9_ready", int'(cmd_ready), 0);
    cmd_valid = 1'b0;
    tick(2);
    chk("hold_done_ready", int'(cmd_ready), 1);
    chk("hold_done_pw", int'(pulse_width), 69500);

    // Clamping: above-max equals current width, then full-left descent
    send(80000);
    chk("clamp_hi_busy", int'(busy), 0);
    send(0);
    chk("clamp_lo_busy", int'(busy), 1);
    run_idle();
    chk("descend_end", int'(pulse_width), 11200);

    // Command equal to current width does nothing
    do_reset();
    send(40350);
    chk("same_busy", int'(busy), 0);
    tick(2);
    chk("same_pw", int'(pulse_width), NEU);

    // Accept coincident with frame_tick
    cmd_valid  = 1'b1;
    cmd_pos    = CNT_W'(69500);
    frame_tick = 1'b1;
    cyc();
    cmd_valid  = 1'b0;
    frame_tick = 1'b0;
    chk("coinc_pw", int'(pulse_width), NEU);
    chk("coinc_busy", int'(busy), 1);
    tick(3);
    chk("coinc_step", int'(pulse_width), 40640);
    run_idle();

    // Asynchronous reset mid-descent at 55000
    send(0);
    repeat (50) tick(2);
    chk("mid_pw", int'(pulse_width), 55000);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pw", int'(pulse_width), NEU);
    chk("async_rst_ready", int'(cmd_ready), 1);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Randomized traffic
    for (int i = 0; i < 30000; i++) begin
      frame_tick = ($urandom_range(0, 3) == 0);
      cmd_valid  = ($urandom_range(0, 30) == 0);
      cmd_pos    = CNT_W'($urandom_range(0, 90000));
      cyc();
    end
    cmd_valid = 1'b0;
    run_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
